// File: rtl/pc_ifid_stall_ctrl.sv
// rtl/pc_ifid_stall_ctrl.sv - PC and IF/ID register owner with stall, flush and stall watchdog
//
// Purpose:
//   Holds the fetch PC and the IF/ID pipeline register. Turns the hazard
//   detector's stall request and the ID-stage branch redirect into PC hold,
//   IF/ID hold, IF/ID flush and an ID/EX bubble. A consecutive-stall
//   watchdog forces one advance after MAX_STALL bubble cycles so the
//   pipeline can never stall forever.
//
// Ports:
//   Clk           in   clock, rising edge
//   Reset         in   asynchronous active-high reset
//   StallReq      in   hazard detector stall request (1 = hold PC and IF/ID)
//   BranchTaken   in   branch resolved taken in ID (flush IF/ID, redirect PC)
//   BranchTarget  in   redirect address, used when BranchTaken=1
//   InstrIn       in   instruction memory read data for the current PC
//   PC            out  current fetch address (registered)
//   IF_IDInstr    out  IF/ID instruction (registered)
//   IF_IDPCPlus4  out  IF/ID PC+4 (registered)
//   ID_EXBubble   out  zero ID/EX controls this cycle (combinational)
//   FlushActive   out  1 for the cycle after a redirect (registered)
//   StallTimeout  out  sticky flag, set when the watchdog forces a release
//
// Optional build macro STALL_PERF_CNT_EN:
//   StallCyclesClr in   synchronous clear of the stall-cycle counter
//   StallCycles    out  saturating count of ID_EXBubble=1 cycles
module pc_ifid_stall_ctrl #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned MAX_STALL = 8,
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        StallReq,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic [31:0] InstrIn,
`ifdef STALL_PERF_CNT_EN
  input  logic        StallCyclesClr,
  output logic [31:0] StallCycles,
`endif
  output logic [31:0] PC,
  output logic [31:0] IF_IDInstr,
  output logic [31:0] IF_IDPCPlus4,
  output logic        ID_EXBubble,
  output logic        FlushActive,
  output logic        StallTimeout
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    STALL = 2'd1,
    FLUSH = 2'd2
  } state_t;

  localparam logic [7:0] MAX_CNT = 8'(MAX_STALL);

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] instr_q, instr_d;
  logic [31:0] pc4_q, pc4_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        flush_q, flush_d;
  logic        timeout_q, timeout_d;
  logic [31:0] pc_plus4;
  logic        hold;

  assign pc_plus4 = pc_q + 32'd4;

  // Stall is honoured only while the streak is below the limit; once the
  // limit is reached a still-asserted StallReq becomes a forced advance.
  assign hold = StallReq & ~BranchTaken & (cnt_q < MAX_CNT);

  assign ID_EXBubble  = hold & ~Reset;
  assign PC           = pc_q;
  assign IF_IDInstr   = instr_q;
  assign IF_IDPCPlus4 = pc4_q;
  assign FlushActive  = flush_q;
  assign StallTimeout = timeout_q;

  always_comb begin
    state_d   = state_q;
    pc_d      = pc_q;
    instr_d   = instr_q;
    pc4_d     = pc4_q;
    cnt_d     = cnt_q;
    flush_d   = 1'b0;
    timeout_d = timeout_q;
    if (BranchTaken) begin
      pc_d    = BranchTarget;
      instr_d = NOP_INSTR;
      pc4_d   = 32'd0;
      cnt_d   = 8'd0;
      flush_d = 1'b1;
      state_d = FLUSH;
    end else if (hold) begin
      cnt_d   = cnt_q + 8'd1;
      state_d = STALL;
    end else begin
      pc_d    = pc_plus4;
      instr_d = InstrIn;
      pc4_d   = pc_plus4;
      state_d = RUN;
      // The streak only builds up inside STALL; RUN and FLUSH enter with it cleared.
      if (state_q == STALL) begin
        cnt_d = 8'd0;
      end
      if (StallReq) begin
        timeout_d = 1'b1;
      end
    end
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_q   <= RUN;
      pc_q      <= RESET_PC;
      instr_q   <= NOP_INSTR;
      pc4_q     <= 32'd0;
      cnt_q     <= 8'd0;
      flush_q   <= 1'b0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      instr_q   <= instr_d;
      pc4_q     <= pc4_d;
      cnt_q     <= cnt_d;
      flush_q   <= flush_d;
      timeout_q <= timeout_d;
    end
  end

`ifdef STALL_PERF_CNT_EN
  logic [31:0] stall_cycles_q;

  // Clear has priority over a same-cycle increment; the count saturates.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      stall_cycles_q <= 32'd0;
    end else if (StallCyclesClr) begin
      stall_cycles_q <= 32'd0;
    end else if (ID_EXBubble && (stall_cycles_q != 32'hFFFF_FFFF)) begin
      stall_cycles_q <= stall_cycles_q + 32'd1;
    end
  end

  assign StallCycles = stall_cycles_q;
`endif

endmodule

// File: tb/tb_pc_ifid_stall_ctrl.sv
// tb/tb_pc_ifid_stall_ctrl.sv - self-checking bench for pc_ifid_stall_ctrl
module tb_pc_ifid_stall_ctrl;

  localparam logic [31:0] RST_PC = 32'h0000_0000;
  localparam int          MAXS   = 8;
  localparam logic [31:0] NOP    = 32'h0000_0013;

  logic        Clk = 1'b0;
  logic        Reset;
  logic        StallReq;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic [31:0] InstrIn;
  logic [31:0] PC;
  logic [31:0] IF_IDInstr;
  logic [31:0] IF_IDPCPlus4;
  logic        ID_EXBubble;
  logic        FlushActive;
  logic        StallTimeout;
`ifdef STALL_PERF_CNT_EN
  logic        StallCyclesClr;
  logic [31:0] StallCycles;
`endif

  int checks   = 0;
  int failures = 0;

  // Reference model: architectural view of PC, IF/ID and the stall streak.
  logic [31:0] m_pc, m_instr, m_pc4;
  logic        m_flush, m_timeout;
  int          m_streak;
  longint      m_cycles;

  pc_ifid_stall_ctrl #(
    .RESET_PC (RST_PC),
    .MAX_STALL(MAXS),
    .NOP_INSTR(NOP)
  ) dut (
    .Clk         (Clk),
    .Reset       (Reset),
    .StallReq    (StallReq),
    .BranchTaken (BranchTaken),
    .BranchTarget(BranchTarget),
    .InstrIn     (InstrIn),
`ifdef STALL_PERF_CNT_EN
    .StallCyclesClr(StallCyclesClr),
    .StallCycles   (StallCycles),
`endif
    .PC          (PC),
    .IF_IDInstr  (IF_IDInstr),
    .IF_IDPCPlus4(IF_IDPCPlus4),
    .ID_EXBubble (ID_EXBubble),
    .FlushActive (FlushActive),
    .StallTimeout(StallTimeout)
  );

  always #5 Clk = ~Clk;

  task automatic check32(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_pc      = RST_PC;
    m_instr   = NOP;
    m_pc4     = 32'd0;
    m_flush   = 1'b0;
    m_timeout = 1'b0;
    m_streak  = 0;
    m_cycles  = 0;
  endtask

  function automatic logic model_bubble();
    return StallReq && !BranchTaken && (m_streak < MAXS);
  endfunction

  task automatic model_edge(input logic clr);
    logic bub;
    bub = model_bubble();
    if (clr) m_cycles = 0;
    else if (bub && m_cycles < 64'hFFFF_FFFF) m_cycles = m_cycles + 1;
    m_flush = BranchTaken;
    if (BranchTaken) begin
      m_pc     = BranchTarget;
      m_instr  = NOP;
      m_pc4    = 32'd0;
      m_streak = 0;
    end else if (bub) begin
      m_streak = m_streak + 1;
    end else begin
      if (StallReq) m_timeout = 1'b1;
      m_instr  = InstrIn;
      m_pc4    = m_pc + 32'd4;
      m_pc     = m_pc + 32'd4;
      m_streak = 0;
    end
  endtask

  task automatic check_state(input string tag);
    check32({tag, "_pc"}, PC, m_pc);
    check32({tag, "_instr"}, IF_IDInstr, m_instr);
    check32({tag, "_pc4"}, IF_IDPCPlus4, m_pc4);
    check32({tag, "_flush"}, {31'd0, FlushActive}, {31'd0, m_flush});
    check32({tag, "_timeout"}, {31'd0, StallTimeout}, {31'd0, m_timeout});
`ifdef STALL_PERF_CNT_EN
    check32({tag, "_stallcycles"}, StallCycles, m_cycles[31:0]);
`endif
  endtask

  // One clock of stimulus: drive, check the bubble, clock, check registers.
  task automatic step(input logic s, input logic b, input logic [31:0] tgt,
                      input logic [31:0] ins, input logic clr, input string tag);
    StallReq     = s;
    BranchTaken  = b;
    BranchTarget = tgt;
    InstrIn      = ins;
`ifdef STALL_PERF_CNT_EN
    StallCyclesClr = clr;
`endif
    #1;
    check32({tag, "_bubble"}, {31'd0, ID_EXBubble}, {31'd0, model_bubble()});
    @(posedge Clk);
    model_edge(clr);
    #1;
    check_state(tag);
  endtask

  initial begin
    int pct;
    Reset        = 1'b1;
    StallReq     = 1'b1;
    BranchTaken  = 1'b0;
    BranchTarget = 32'd0;
    InstrIn      = 32'd0;
`ifdef STALL_PERF_CNT_EN
    StallCyclesClr = 1'b0;
`endif
    model_reset();
    repeat (2) @(posedge Clk);
    #1;
    check_state("reset");
    check32("reset_bubble", {31'd0, ID_EXBubble}, 32'd0);
    StallReq = 1'b0;
    @(negedge Clk);
    Reset = 1'b0;

    // Advance from reset, then a two-cycle stall at PC=0x8.
    step(1'b0, 1'b0, 32'd0, 32'h2008_0005, 1'b0, "adv1");
    check32("adv1_pc_const", PC, 32'h4);
    check32("adv1_instr_const", IF_IDInstr, 32'h2008_0005);
    check32("adv1_pc4_const", IF_IDPCPlus4, 32'h4);
    step(1'b0, 1'b0, 32'd0, 32'h2008_0005, 1'b0, "adv2");
    check32("adv2_pc_const", PC, 32'h8);
    step(1'b1, 1'b0, 32'd0, 32'h1111_1111, 1'b0, "stall1");
    check32("stall1_pc_const", PC, 32'h8);
    step(1'b1, 1'b0, 32'd0, 32'h2222_2222, 1'b0, "stall2");
    check32("stall2_instr_const", IF_IDInstr, 32'h2008_0005);
    step(1'b0, 1'b0, 32'd0, 32'h3333_3333, 1'b0, "release");
    check32("release_pc_const", PC, 32'hC);

    // Branch beats a same-cycle stall request.
    step(1'b1, 1'b1, 32'h40, 32'h4444_4444, 1'b0, "br_stall");
    check32("br_stall_pc_const", PC, 32'h40);
    check32("br_stall_instr_const", IF_IDInstr, NOP);
    check32("br_stall_flush_const", {31'd0, FlushActive}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'h5555_5555, 1'b0, "flush_exit");
    check32("flush_exit_const", {31'd0, FlushActive}, 32'd0);
    step(1'b0, 1'b1, 32'h80, 32'd0, 1'b0, "br_b2b1");
    step(1'b0, 1'b1, 32'h0000_0103, 32'd0, 1'b0, "br_b2b2");
    check32("b2b_flush_const", {31'd0, FlushActive}, 32'd1);

    // Watchdog: MAXS bubbles, a forced advance, then bubbles resume.
    for (int i = 0; i < MAXS; i++) step(1'b1, 1'b0, 32'd0, 32'h6666_6666, 1'b0, "wd_stall");
    StallReq = 1'b1;
    #1;
    check32("wd_forced_bubble_const", {31'd0, ID_EXBubble}, 32'd0);
    step(1'b1, 1'b0, 32'd0, 32'h7777_7777, 1'b0, "wd_forced");
    check32("wd_timeout_const", {31'd0, StallTimeout}, 32'd1);
    check32("wd_forced_instr_const", IF_IDInstr, 32'h7777_7777);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, "wd_resume");
    check32("wd_resume_bubble_const", {31'd0, ID_EXBubble}, 32'd1);
    step(1'b0, 1'b0, 32'd0, 32'h8888_8888, 1'b0, "wd_release");
    check32("wd_sticky_const", {31'd0, StallTimeout}, 32'd1);

    // PC wrap at the top of the address space.
    step(1'b0, 1'b1, 32'hFFFF_FFFC, 32'd0, 1'b0, "wrap_br");
    step(1'b0, 1'b0, 32'd0, 32'h9999_9999, 1'b0, "wrap");
    check32("wrap_pc_const", PC, 32'h0);

`ifdef STALL_PERF_CNT_EN
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b1, "perf_clr0");
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, "perf_stall");
    check32("perf_five_const", StallCycles, 32'd5);
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b1, "perf_clr");
    check32("perf_clr_const", StallCycles, 32'd0);
    step(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, "perf_end");
`endif

    // Random traffic in blocks with light or heavy stall pressure.
    for (int blk = 0; blk < 20; blk++) begin
      pct = (blk % 2 == 0) ? 30 : 95;
      for (int i = 0; i < 20; i++) begin
        step(($urandom_range(0, 99) < pct), ($urandom_range(0, 99) < 8), $urandom, $urandom,
             ($urandom_range(0, 99) < 5), "rnd");
      end
    end

    // Force StallTimeout high, then reset mid-stall between clock edges.
    for (int i = 0; i <= MAXS; i++) step(1'b1, 1'b0, 32'd0, 32'hAAAA_0000, 1'b0, "pre_rst");
    step(1'b1, 1'b0, 32'd0, 32'd0, 1'b0, "mid_stall");
    #2;
    Reset = 1'b1;
    #1;
    model_reset();
    check_state("async_rst");
    check32("async_rst_pc_const", PC, RST_PC);
    check32("async_rst_timeout_const", {31'd0, StallTimeout}, 32'd0);
    check32("async_rst_bubble_const", {31'd0, ID_EXBubble}, 32'd0);
    @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    step(1'b0, 1'b0, 32'd0, 32'hBEEF_0001, 1'b0, "post_rst");
    check32("post_rst_pc_const", PC, 32'h4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pc_ifid_stall_ctrl.md
Name: pc_ifid_stall_ctrl

Overview:
Consumer of the data hazard detector's stall outputs. It owns the program counter and the IF/ID pipeline register, and turns the detector's stall request (1 = stall) and the branch-taken/flush request into PC hold, IF/ID hold, IF/ID flush and ID/EX bubble behaviour. A consecutive-stall watchdog guarantees the pipeline cannot stall forever.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset
MAX_STALL, 8, consecutive stall cycles allowed before forced release (range 1..255)
NOP_INSTR, 32'h0000_0000, instruction word inserted on flush and on reset

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  asynchronous, active-high reset
StallReq  input  1  stall request from hazard detector (1 = hold PC and IF/ID)
BranchTaken  input  1  branch resolved taken in ID; flush IF/ID and redirect PC
BranchTarget  input  32  redirect address, valid when BranchTaken=1
InstrIn  input  32  instruction memory read data for the current PC
PC  output  32  current fetch address (registered)
IF_IDInstr  output  32  IF/ID instruction (registered)
IF_IDPCPlus4  output  32  IF/ID PC+4 (registered)
ID_EXBubble  output  1  zero ID/EX control signals this cycle (combinational)
FlushActive  output  1  registered; 1 for the cycle after a redirect
StallTimeout  output  1  sticky; set when the watchdog forces a release

Behaviour:
- Single clock domain, one clock, asynchronous active-high Reset. All state clears immediately on Reset assertion.
- Reset values:
  - PC=RESET_PC, IF_IDInstr=NOP_INSTR, IF_IDPCPlus4=0.
  - FlushActive=0, StallTimeout=0, stall count=0, state=RUN.
  - ID_EXBubble=0 while Reset is high.
- States: RUN, STALL, FLUSH.
- Priority each cycle: BranchTaken > forced release > StallReq > normal advance.
- Normal advance (RUN or FLUSH, StallReq=0, BranchTaken=0):
  - PC<=PC+4, 32-bit wrap (32'hFFFF_FFFC -> 0).
  - IF_IDInstr<=InstrIn, IF_IDPCPlus4<=PC+4.
  - Next state RUN.
- Stall (StallReq=1, BranchTaken=0, count<MAX_STALL):
  - PC, IF_IDInstr and IF_IDPCPlus4 hold. ID_EXBubble=1 in the same cycle.
  - Count increments. Next state STALL.
- Forced release (StallReq=1 and count==MAX_STALL):
  - Treated as a normal advance; ID_EXBubble=0.
  - StallTimeout<=1 (sticky until Reset). Count<=0. Next state RUN.
- StallReq=0 in STALL: count<=0, normal advance, next state RUN.
- Branch redirect (BranchTaken=1, any state, StallReq ignored):
  - PC<=BranchTarget, IF_IDInstr<=NOP_INSTR, IF_IDPCPlus4<=0, count<=0.
  - FlushActive<=1, next state FLUSH. ID_EXBubble=0.
- FLUSH lasts exactly one cycle: FlushActive<=0 on exit unless another BranchTaken arrives. Back-to-back branches re-enter FLUSH.
- ID_EXBubble = StallReq & ~BranchTaken & ~Reset & (count<MAX_STALL). It is purely a function of current inputs and state.
- BranchTarget is taken unmodified; no alignment check.
- Reset mid-stall or mid-flush: all state returns to reset values asynchronously. The first advance happens on the first rising edge after deassertion.

Optional Feature:
STALL_PERF_CNT_EN
- Defined: adds output StallCycles (32-bit) and input StallCyclesClr (1-bit).
  - StallCycles increments every cycle ID_EXBubble=1, saturating at 32'hFFFF_FFFF.
  - StallCyclesClr=1 zeroes it synchronously; clear wins over a same-cycle increment.
  - Reset clears it.
- Undefined: neither port exists; no counter logic is present.

Test Plan:
- Reset release with InstrIn=32'h2008_0005, no stalls, 3 cycles -> PC=0x4, 0x8, 0xC; IF_IDInstr=32'h2008_0005; IF_IDPCPlus4=0x4 after the first edge.
- StallReq=1 for 2 cycles at PC=0x8 -> PC holds 0x8 and IF_ID holds; ID_EXBubble=1 both cycles; PC=0xC on the first edge after StallReq drops.
- BranchTaken=1 and StallReq=1 together, BranchTarget=0x40 -> PC=0x40, IF_IDInstr=NOP, FlushActive=1 for one cycle, ID_EXBubble=0.
- StallReq held high with MAX_STALL=8 -> 8 bubble cycles, then one forced advance with ID_EXBubble=0; StallTimeout=1 and stays 1; bubbles resume.
- PC=32'hFFFF_FFFC, no stall -> PC wraps to 0; Reset asserted mid-stall -> PC=RESET_PC and StallTimeout=0 immediately, without waiting for a clock edge.
- With STALL_PERF_CNT_EN: 5 stall cycles -> StallCycles=5; StallCyclesClr coincident with a stall -> StallCycles=0.
